// File: rtl/arm_shift_pkg.sv
// Shared ARM register-shift definitions: shift-type encodings, default widths, requester ids.
// Optional carry support is selected with the VAL2_SHIFT_CARRY_EN macro.
package arm_shift_pkg;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   localparam int DEF_DW = 32;
   localparam int DEF_AW = 8;

   localparam logic REQ_EXE = 1'b0;
   localparam logic REQ_MEM = 1'b1;

`ifdef VAL2_SHIFT_CARRY_EN
   localparam logic CARRY_EN = 1'b1;
`else
   localparam logic CARRY_EN = 1'b0;
`endif

endpackage

// File: rtl/val2_shift_arbiter_if.sv
// Request/result bundle of val2_shift_arbiter; cpsr_c/res_carry exist only with VAL2_SHIFT_CARRY_EN.
interface val2_shift_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [DW-1:0] req0_data;
   logic [1:0]    req0_type;
   logic [AW-1:0] req0_amt;
   logic [DW-1:0] req1_data;
   logic [1:0]    req1_type;
   logic [AW-1:0] req1_amt;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_id;
`ifdef VAL2_SHIFT_CARRY_EN
   logic          cpsr_c;
   logic          res_carry;
`endif

   modport master (
`ifdef VAL2_SHIFT_CARRY_EN
      output cpsr_c,
      input  res_carry,
`endif
      output req_valid, req0_data, req0_type, req0_amt,
      output req1_data, req1_type, req1_amt, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
`ifdef VAL2_SHIFT_CARRY_EN
      input  cpsr_c,
      output res_carry,
`endif
      input  req_valid, req0_data, req0_type, req0_amt,
      input  req1_data, req1_type, req1_amt, res_ready,
      output req_ready, res_valid, res_data, res_id
   );
endinterface

// File: rtl/arm_reg_shifter.sv
// Combinational ARM register-specified shifter (LSL/LSR/ASR/ROR, amount from Rs[7:0]).
// With VAL2_SHIFT_CARRY_EN it also produces the shifter carry-out.
module arm_reg_shifter
   import arm_shift_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic [DW-1:0] data,
   input  logic [1:0]    shift_type,
   input  logic [AW-1:0] amt,
`ifdef VAL2_SHIFT_CARRY_EN
   input  logic          cin,
   output logic          cout,
`endif
   output logic [DW-1:0] result
);
   localparam int SW = $clog2(DW);
   localparam logic [SW:0] DW_W = (SW+1)'(DW);

   logic          zero_s;
   logic          big_s;
   logic [SW-1:0] sh_s;
   logic [SW:0]   ror_left_s;

   assign zero_s     = (amt == {AW{1'b0}});
   assign big_s      = (amt >= AW'(DW));
   assign sh_s       = amt[SW-1:0];
   assign ror_left_s = DW_W - {1'b0, sh_s};

   // Shift result; ROR by a multiple of DW collapses to the operand itself
   always_comb begin
      result = data;
      case (shift_type)
         SH_LSL:  result = zero_s ? data : (big_s ? {DW{1'b0}} : (data << sh_s));
         SH_LSR:  result = zero_s ? data : (big_s ? {DW{1'b0}} : (data >> sh_s));
         SH_ASR:  result = zero_s ? data : (big_s ? {DW{data[DW-1]}}
                                                 : $unsigned($signed(data) >>> sh_s));
         SH_ROR:  result = (data >> sh_s) | (data << ror_left_s);
         default: result = data;
      endcase
   end

`ifdef VAL2_SHIFT_CARRY_EN
   logic          over_s;
   logic [SW-1:0] lsl_idx_s;
   logic [SW-1:0] lsr_idx_s;

   assign over_s    = (amt > AW'(DW));
   assign lsl_idx_s = {SW{1'b0}} - sh_s;
   assign lsr_idx_s = sh_s - {{(SW-1){1'b0}}, 1'b1};

   // Last bit shifted out; modulo-DW indices make amt==DW land on d[0]/d[DW-1]
   always_comb begin
      cout = cin;
      if (zero_s) begin
         cout = cin;
      end else begin
         case (shift_type)
            SH_LSL:  cout = over_s ? 1'b0 : data[lsl_idx_s];
            SH_LSR:  cout = over_s ? 1'b0 : data[lsr_idx_s];
            SH_ASR:  cout = big_s ? data[DW-1] : data[lsr_idx_s];
            SH_ROR:  cout = data[lsr_idx_s];
            default: cout = cin;
         endcase
      end
   end
`endif

endmodule

// File: rtl/val2_shift_arbiter.sv
// Round-robin arbiter sharing one register-shift unit between EXE (req 0) and MEM (req 1).
// VAL2_SHIFT_CARRY_EN adds cpsr_c input and registered res_carry output.
module val2_shift_arbiter
   import arm_shift_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input logic                clk,
   input logic                rst_n,
   val2_shift_arbiter_if.slave bus
);
   logic          free_s;
   logic          grant_vld_s;
   logic          grant_id_s;
   logic          accept_s;
   logic [1:0]    req_ready_s;
   logic [DW-1:0] sel_data_s;
   logic [1:0]    sel_type_s;
   logic [AW-1:0] sel_amt_s;
   logic [DW-1:0] shift_res_s;

   logic          rr_ptr_r;
   logic          res_valid_r;
   logic [DW-1:0] res_data_r;
   logic          res_id_r;

   assign free_s   = !res_valid_r || bus.res_ready;
   assign accept_s = free_s && grant_vld_s;

   // Grant choice: a lone requester wins, contention goes to rr_ptr
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = REQ_EXE;
      case (bus.req_valid)
         2'b01: begin
            grant_vld_s = 1'b1;
            grant_id_s  = REQ_EXE;
         end
         2'b10: begin
            grant_vld_s = 1'b1;
            grant_id_s  = REQ_MEM;
         end
         2'b11: begin
            grant_vld_s = 1'b1;
            grant_id_s  = rr_ptr_r;
         end
         default: begin
            grant_vld_s = 1'b0;
            grant_id_s  = REQ_EXE;
         end
      endcase
   end

   // One-hot ready, gated only by the output register being free
   always_comb begin
      req_ready_s = 2'b00;
      if (accept_s) begin
         if (grant_id_s == REQ_MEM) begin
            req_ready_s = 2'b10;
         end else begin
            req_ready_s = 2'b01;
         end
      end else begin
         req_ready_s = 2'b00;
      end
   end

   // Operand mux ahead of the single shared shifter
   always_comb begin
      sel_data_s = bus.req0_data;
      sel_type_s = bus.req0_type;
      sel_amt_s  = bus.req0_amt;
      if (grant_id_s == REQ_MEM) begin
         sel_data_s = bus.req1_data;
         sel_type_s = bus.req1_type;
         sel_amt_s  = bus.req1_amt;
      end else begin
         sel_data_s = bus.req0_data;
         sel_type_s = bus.req0_type;
         sel_amt_s  = bus.req0_amt;
      end
   end

`ifdef VAL2_SHIFT_CARRY_EN
   logic shift_carry_s;
   logic res_carry_r;

   arm_reg_shifter #(.DW(DW), .AW(AW)) u_shifter (
      .data       (sel_data_s),
      .shift_type (sel_type_s),
      .amt        (sel_amt_s),
      .cin        (bus.cpsr_c),
      .cout       (shift_carry_s),
      .result     (shift_res_s)
   );

   // Carry register travels with res_data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_carry_r <= 1'b0;
      end else if (accept_s) begin
         res_carry_r <= shift_carry_s;
      end
   end

   assign bus.res_carry = res_carry_r;
`else
   arm_reg_shifter #(.DW(DW), .AW(AW)) u_shifter (
      .data       (sel_data_s),
      .shift_type (sel_type_s),
      .amt        (sel_amt_s),
      .result     (shift_res_s)
   );
`endif

   // Output register and round-robin pointer; reset drops any held result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_r <= 1'b0;
         res_data_r  <= {DW{1'b0}};
         res_id_r    <= REQ_EXE;
         rr_ptr_r    <= REQ_EXE;
      end else if (accept_s) begin
         res_valid_r <= 1'b1;
         res_data_r  <= shift_res_s;
         res_id_r    <= grant_id_s;
         rr_ptr_r    <= ~grant_id_s;
      end else if (bus.res_ready) begin
         res_valid_r <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = res_data_r;
   assign bus.res_id    = res_id_r;

endmodule

// File: doc/val2_shift_arbiter.md
Name: val2_shift_arbiter

Overview:
- Shares one register-specified shift/rotate unit between two requesters:
  - req 0: EXE-stage operand-2 path, for shifts by Rs.
  - req 1: MEM-stage scaled-offset path.
- Requests are granted round-robin and shifted by ARM register-shift rules.
- The result is held in a single output register with valid/ready backpressure.
- Sits beside the Val2 generator in EXE; handles the shift_operand[4]=1 case that the immediate-amount path does not cover.

Parameters:
- DW, 32, operand/result width (fixed 32 for ARM; other values unsupported).
- AW, 8, shift-amount width (Rs[7:0]).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both 1.
- req0_data  in  DW  requester 0 operand (Rm value).
- req0_type  in  2  requester 0 shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- req0_amt  in  AW  requester 0 shift amount.
- req1_data, req1_type, req1_amt  in  DW/2/AW  same fields for requester 1.
- res_valid  out  1  result register holds valid data.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DW  shifted result.
- res_id  out  1  index of the requester that owns res_data.

Behaviour:
- Reset (async, rst_n=0) clears res_valid, res_data, res_id and rr_ptr (priority pointer = req 0). Reset mid-transfer drops any held result with no replay.
- Output register is "free" when res_valid=0 or (res_valid and res_ready).
- Arbitration is combinational each cycle and only happens when the register is free. If it is not free, req_ready=00.
- If only one req_valid is set, that requester is granted.
- If both are set, the grant goes to rr_ptr.
- req_ready is one-hot to the granted requester and never depends on res_ready through any path other than "free".
- On an accepted transfer:
  - res_data and res_id are loaded and res_valid=1 at the next edge (latency 1 cycle).
  - rr_ptr is set to ~granted id.
- With no accept: res_valid clears if res_ready=1 while it is valid; otherwise the result holds stable.
- Back-to-back operation: one result per cycle while res_ready stays 1.
- A requester may drop req_valid before it is granted; no state is kept for ungranted requests.
- Shift rules (a = amount, d = data):
  - LSL: a=0 → d; 1..31 → d<<a; a≥32 → 0.
  - LSR: a=0 → d; 1..31 → logical d>>a; a≥32 → 0.
  - ASR: a=0 → d; 1..31 → arithmetic shift; a≥32 → {32{d[31]}}.
  - ROR: a=0 → d; otherwise rotate right by a[4:0]. A multiple of 32 gives d.
- Shift amounts are unsigned AW bits. No RRX in this block.

Optional Feature:
- Macro: VAL2_SHIFT_CARRY_EN.
- When defined:
  - Adds input cpsr_c (1) and output res_carry (1), registered with res_data and reset to 0.
  - Carry is the last bit shifted out, per ARM rules:
    - a=0 → cpsr_c.
    - LSL 1..32 → d[32-a]; LSL >32 → 0.
    - LSR 1..32 → d[a-1]; LSR >32 → 0.
    - ASR ≥32 → d[31].
    - ROR nonzero → bit d[(a-1) mod 32].
- When not defined: no ports are added and no carry logic is built.

Decomposition:
- Shared package (arm_shift_pkg) holds:
  - shift-type constants SH_LSL/SH_LSR/SH_ASR/SH_ROR.
  - DW/AW defaults.
  - requester index constants REQ_EXE=0 and REQ_MEM=1.
- One natural sub-module: arm_reg_shifter. It is purely combinational (data, type, amt[, cin] → result[, cout]) and is instantiated once after the grant mux.
- Arbiter, round-robin pointer and output register live in the top module.

Test Plan:
- Reset then single request: req0 LSL d=0x0000_0001 a=4 → req_ready=01; next cycle res_valid=1, res_data=0x0000_0010, res_id=0.
- Contention with round-robin: both valid every cycle, res_ready=1 → grants alternate 0,1,0,1. Results appear one per cycle; res_id follows the same order.
- Backpressure: res_ready=0 with a result held and both requesting → req_ready=00 and res_data stays stable for 5 cycles. When res_ready=1, that same cycle accepts the next request.
- Boundaries for d=0x8000_0000:
  - LSR a=32 → 0.
  - ASR a=40 → 0xFFFF_FFFF.
  - LSL a=255 → 0.
  - ROR a=32 → 0x8000_0000.
  - ROR a=1 → 0x4000_0000.
  - a=0 for each type → d unchanged.
- Async reset mid-stream: assert rst_n=0 between edges while res_valid=1 → res_valid=0 immediately and rr_ptr=0. After release with both valid, req 0 is granted first.
- With VAL2_SHIFT_CARRY_EN:
  - LSR d=0x0000_0003 a=1 → res_carry=1.
  - LSL d=0x1 a=33 → res_carry=0.
  - a=0 with cpsr_c=1 → res_carry=1.
